// File: rtl/multi_one_shot.sv
// Multi-channel one-shot: CH independent channels, each emits a PW-cycle pulse per activation.
// Optional per-channel debounce on the synchronised trigger when ONESHOT_DEBOUNCE_EN is defined.

module multi_one_shot_ch #(
    parameter int PW = 1,
    parameter int DB = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    input  logic pol,
    output logic s,
    output logic busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, HOLD = 2'd2} state_t;

    localparam int CW = $clog2(PW + 1);

    if (PW < 1 || DB < 2) begin : g_param_chk
        $error("multi_one_shot: need PW >= 1 and DB >= 2");
    end

    logic          sync1, sync2, lvl, a;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          s_n, busy_n;

    // Reset loads the inactive level so a held trigger is not seen as already armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= pol;
            sync2 <= pol;
        end else begin
            sync1 <= trig;
            sync2 <= sync1;
        end
    end

`ifdef ONESHOT_DEBOUNCE_EN
    localparam int DBW = $clog2(DB);
    logic           db;
    logic [DBW-1:0] dbc;

    always_ff @(posedge clk) begin
        if (rst) begin
            db  <= pol;
            dbc <= '0;
        end else if (sync2 != db) begin
            if (dbc == DBW'(DB - 1)) begin
                db  <= sync2;
                dbc <= '0;
            end else begin
                dbc <= dbc + DBW'(1);
            end
        end else begin
            dbc <= '0;
        end
    end

    assign lvl = db;
`else
    assign lvl = sync2;
`endif

    assign a = lvl ^ pol;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            s     <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            s     <= s_n;
            busy  <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        s_n     = s;
        busy_n  = busy;
        case (state)
            IDLE: begin
                s_n    = 1'b0;
                busy_n = 1'b0;
                if (a) begin
                    state_n = PULSE;
                    cnt_n   = CW'(PW - 1);
                    s_n     = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            PULSE: begin
                s_n    = 1'b1;
                busy_n = 1'b1;
                if (cnt == '0) begin
                    state_n = HOLD;
                    s_n     = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            HOLD: begin
                s_n    = 1'b0;
                busy_n = 1'b1;
                if (!a) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                s_n     = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end
endmodule

module multi_one_shot #(
    parameter int CH = 4,
    parameter int PW = 1,
    parameter int DB = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] trig_i,
    input  logic [CH-1:0] pol,
    output logic [CH-1:0] s,
    output logic [CH-1:0] busy
);
    for (genvar i = 0; i < CH; i++) begin : g_ch
        multi_one_shot_ch #(.PW(PW), .DB(DB)) u_ch (
            .clk  (clk),
            .rst  (rst),
            .trig (trig_i[i]),
            .pol  (pol[i]),
            .s    (s[i]),
            .busy (busy[i])
        );
    end
endmodule

// File: tb/tb_multi_one_shot.sv
// Directed bench for multi_one_shot (CH=4, PW=3, DB=4); debounce scenarios run when
// ONESHOT_DEBOUNCE_EN is defined, short-trigger scenarios otherwise.

module tb_multi_one_shot;
    localparam int CH = 4;
    localparam int PW = 3;
    localparam int DB = 4;
`ifdef ONESHOT_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] trig;
    logic [CH-1:0] pol;
    logic [CH-1:0] s, busy;

    int n_chk = 0;
    int n_err = 0;

    multi_one_shot #(.CH(CH), .PW(PW), .DB(DB)) dut (
        .clk    (clk),
        .rst    (rst),
        .trig_i (trig),
        .pol    (pol),
        .s      (s),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trigger already applied before E0; optionally drop it after 'drop' edges.
    task automatic pulse_seq(input string tag, input logic [CH-1:0] mask, input int drop);
        for (int t = 0; t <= LAT + PW; t++) begin
            tick();
            chk($sformatf("%s_s_t%0d", tag, t), 32'(s & mask),
                (t >= LAT && t < LAT + PW) ? 32'(mask) : 32'h0);
            if (drop != 0 && t + 1 == drop) trig = trig & ~mask;
        end
    endtask

    // Inactive level already applied before F0; busy drops after F(LAT).
    task automatic release_seq(input string tag, input logic [CH-1:0] mask);
        for (int t = 0; t <= LAT; t++) begin
            tick();
            chk($sformatf("%s_busy_t%0d", tag, t), 32'(busy & mask),
                (t < LAT) ? 32'(mask) : 32'h0);
            chk($sformatf("%s_s_t%0d", tag, t), 32'(s & mask), 32'h0);
        end
    endtask

    initial begin
        rst  = 1'b1;
        trig = 4'hF;
        pol  = 4'h0;

        // 1: reset with triggers held high, then pulses on release
        for (int t = 0; t < 2; t++) begin
            tick();
            chk("rst_s", 32'(s), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
        end
        rst = 1'b0;
        pulse_seq("rst_rel", 4'hF, 0);
        chk("rst_rel_hold_busy", 32'(busy), 32'hF);
        trig = 4'h0;
        release_seq("rst_rel_off", 4'hF);

        // 2: basic long trigger on channel 0
        trig = 4'h1;
        pulse_seq("basic", 4'h1, 0);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("basic_no_retrig", 32'(s), 32'h0);
            chk("basic_hold", 32'(busy), 32'h1);
        end
        trig = 4'h0;
        release_seq("basic_off", 4'h1);

        // 3: active-low channel 1; reset loads the high idle level
        pol  = 4'h2;
        trig = 4'h2;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("pol_idle", 32'(s | busy), 32'h0);
        end
        trig = 4'h0;
        pulse_seq("pol", 4'h2, 0);
        trig = 4'h2;
        release_seq("pol_rise", 4'h2);

`ifndef ONESHOT_DEBOUNCE_EN
        // 4: one-cycle trigger, a second one inside PULSE, a third after re-arm
        trig = 4'h4;
        tick(); chk("short_e0", 32'(s[2]), 32'h0);
        trig = 4'h0;
        tick(); chk("short_e1", 32'(s[2]), 32'h0);
        tick(); chk("short_e2", 32'(s[2]), 32'h1);
        trig = 4'h4;
        tick(); chk("short_e3", 32'(s[2]), 32'h1);
        trig = 4'h0;
        tick(); chk("short_e4", 32'(s[2]), 32'h1);
        tick(); chk("short_e5", 32'(s[2]), 32'h0);
        chk("short_e5_busy", 32'(busy[2]), 32'h1);
        tick(); chk("short_e6_busy", 32'(busy[2]), 32'h0);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("short_ignored", 32'(s[2]), 32'h0);
        end
        trig = 4'h4;
        pulse_seq("short_third", 4'h4, 1);
        tick(); chk("short_third_idle", 32'(busy[2]), 32'h0);
`else
        // 5: three-cycle glitch is filtered, four-cycle assertion fires
        trig = 4'h8;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (t == 2) trig = 4'h0;
            chk("db_glitch", 32'(s[3] | busy[3]), 32'h0);
        end
        trig = 4'h8;
        pulse_seq("db_fire", 4'h8, 4);
        for (int t = 0; t < LAT + 2; t++) tick();
        chk("db_release", 32'(busy[3]), 32'h0);
`endif

        // 6: all channels together, then reset during the second pulse cycle
        pol  = 4'h0;
        trig = 4'h0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("conc_idle", 32'(s | busy), 32'h0);
        trig = 4'hF;
        for (int t = 0; t <= LAT + 1; t++) begin
            tick();
            chk("conc_s", 32'(s), (t >= LAT) ? 32'hF : 32'h0);
        end
        rst = 1'b1;
        tick();
        chk("conc_rst_s", 32'(s), 32'h0);
        chk("conc_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        trig = 4'h0;
        for (int t = 0; t < 2 * LAT + PW + 4; t++) tick();
        chk("conc_drain_busy", 32'(busy), 32'h0);
        chk("conc_drain_s", 32'(s), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
